// File: rtl/feature_in_buffer_pkg.sv
// rtl/feature_in_buffer_pkg.sv - shared bank-state enum and default widths for the feature input buffer
//
// Package feature_buf_pkg:
//   FEATURE_ADDR_W / FEATURE_DATA_W : default word address / data widths shared with fetch
//   bank_state_e                    : per-bank ping-pong state
//   bank_writable / bank_readable   : state decodes used by the buffer FSMs
package feature_buf_pkg;

    localparam int FEATURE_ADDR_W = 15;
    localparam int FEATURE_DATA_W = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_e;

    // Fetch may target a bank only while it is being filled or is free.
    function automatic logic bank_writable(input bank_state_e s);
        return (s == BANK_EMPTY) || (s == BANK_FILLING);
    endfunction

    // Compute may read a bank only once fetch has declared it complete.
    function automatic logic bank_readable(input bank_state_e s);
        return (s == BANK_FULL) || (s == BANK_READING);
    endfunction

endpackage

// File: rtl/feature_in_buffer_if.sv
// rtl/feature_in_buffer_if.sv - fetch/compute bus of the feature input buffer
//
// Interface feature_in_buffer_if (ADDR_W, DATA_W):
//   write side : wr_en, wr_addr, wr_data, i_mem_select, wr_done, wr_ready[1:0]
//   read side  : rd_en, rd_addr, rd_done, rd_data, rd_valid, rd_ready, rd_bank
//   status     : err[1:0], wr_count0, wr_count1
// Modports:
//   master : fetch/compute side (drives strobes, observes status)
//   slave  : the buffer itself
interface feature_in_buffer_if
    import feature_buf_pkg::*;
#(
    parameter int ADDR_W = FEATURE_ADDR_W,
    parameter int DATA_W = FEATURE_DATA_W
);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              i_mem_select;
    logic              wr_done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_done;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_bank;
    logic [1:0]        wr_ready;
    logic [1:0]        err;
    logic [ADDR_W:0]   wr_count0;
    logic [ADDR_W:0]   wr_count1;

    modport master (
        output wr_en, wr_addr, wr_data, i_mem_select, wr_done,
        output rd_en, rd_addr, rd_done,
        input  rd_data, rd_valid, rd_ready, rd_bank, wr_ready, err,
        input  wr_count0, wr_count1
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, i_mem_select, wr_done,
        input  rd_en, rd_addr, rd_done,
        output rd_data, rd_valid, rd_ready, rd_bank, wr_ready, err,
        output wr_count0, wr_count1
    );

endinterface

// File: rtl/feature_in_buffer_bank_ram.sv
// rtl/feature_in_buffer_bank_ram.sv - one bank of feature storage, simple dual-port RAM
//
// Module feature_bank_ram (ADDR_W, DATA_W, DEPTH):
//   clk, rst       : clock, synchronous active-low reset (read register only)
//   we, waddr, wdata : write port, written on the rising edge
//   re, raddr      : read request; data appears on rdata the following cycle
//   rdata          : registered read data, holds its value when re is low
// Addresses must already be range-checked against DEPTH by the caller.
module feature_bank_ram #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is intentionally not reset; stale contents are unreachable
    // until the bank is refilled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    // Read-before-write: a same-address write in the same cycle is not seen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr[IDX_W-1:0]];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/feature_in_buffer.sv
// rtl/feature_in_buffer.sv - double-banked (ping-pong) feature input buffer between fetch and compute
//
// Module feature_in_buffer (ADDR_W, DATA_W, DEPTH):
//   clk  : single clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : feature_in_buffer_if.slave (write strobes from fetch, read strobes
//          from compute, read data, ready/state decodes, sticky err, counts)
// Optional feature: define FEATURE_BUF_CNT_EN to build the per-bank
// saturating accepted-write counters; otherwise wr_count0/1 are tied to 0.
module feature_in_buffer
    import feature_buf_pkg::*;
#(
    parameter int ADDR_W = FEATURE_ADDR_W,
    parameter int DATA_W = FEATURE_DATA_W,
    parameter int DEPTH  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    feature_in_buffer_if.slave   bus
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    bank_state_e       state_q [2];
    bank_state_e       state_d [2];
    bank_state_e       post_free [2];
    logic              rd_bank_q, rd_bank_d;
    logic              rd_sel_q, rd_sel_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_ready_q, rd_ready_d;
    logic [1:0]        wr_ready_q, wr_ready_d;
    logic [1:0]        err_q, err_d;

    logic              wr_in_range, rd_in_range;
    logic              rd_free, rd_accept, wr_accept, wr_done_ok;
    logic [DATA_W-1:0] bank_rdata [2];

    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_LIM);
    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_LIM);

    // Bank FSMs, rd_bank and error flags. Within one cycle the events are
    // applied in a fixed order: rd_done free, rd_en FULL->READING, write
    // acceptance (against the post-free state), then wr_done.
    always_comb begin
        rd_free    = bus.rd_done && bank_readable(state_q[rd_bank_q]);
        rd_accept  = bus.rd_en && bank_readable(state_q[rd_bank_q]) && rd_in_range;

        for (int b = 0; b < 2; b++) begin
            post_free[b] = state_q[b];
            if (rd_bank_q == b[0]) begin
                if (rd_free) begin
                    post_free[b] = BANK_EMPTY;
                end else if (bus.rd_en && (state_q[b] == BANK_FULL)) begin
                    post_free[b] = BANK_READING;
                end
            end
        end

        wr_accept  = bus.wr_en && wr_in_range && bank_writable(post_free[bus.i_mem_select]);
        wr_done_ok = bus.wr_done && bank_writable(post_free[bus.i_mem_select]);

        for (int b = 0; b < 2; b++) begin
            state_d[b] = post_free[b];
            if (bus.i_mem_select == b[0]) begin
                if (wr_accept && (post_free[b] == BANK_EMPTY)) begin
                    state_d[b] = BANK_FILLING;
                end
                if (wr_done_ok) begin
                    state_d[b] = BANK_FULL;
                end
            end
        end

        rd_bank_d  = rd_free ? ~rd_bank_q : rd_bank_q;
        rd_sel_d   = rd_accept ? rd_bank_q : rd_sel_q;
        rd_valid_d = rd_accept;

        // Ready outputs are decodes of the next state, registered alongside it.
        rd_ready_d = bank_readable(state_d[rd_bank_d]);
        for (int b = 0; b < 2; b++) begin
            wr_ready_d[b] = bank_writable(state_d[b]);
        end

        err_d    = err_q;
        if ((bus.wr_en && !wr_accept) || (bus.wr_done && !wr_done_ok)) begin
            err_d[0] = 1'b1;
        end
        if (bus.rd_en && !rd_accept) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            rd_bank_q  <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_ready_q <= 1'b0;
            wr_ready_q <= 2'b11;
            err_q      <= 2'b00;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            rd_bank_q  <= rd_bank_d;
            rd_sel_q   <= rd_sel_d;
            rd_valid_q <= rd_valid_d;
            rd_ready_q <= rd_ready_d;
            wr_ready_q <= wr_ready_d;
            err_q      <= err_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        feature_bank_ram #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_ram (
            .clk   (clk),
            .rst   (rst),
            .we    (wr_accept && (bus.i_mem_select == 1'(g))),
            .waddr (bus.wr_addr),
            .wdata (bus.wr_data),
            .re    (rd_accept && (rd_bank_q == 1'(g))),
            .raddr (bus.rd_addr),
            .rdata (bank_rdata[g])
        );
    end

`ifdef FEATURE_BUF_CNT_EN
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] cnt_q [2];
    logic [ADDR_W:0] cnt_d [2];

    // Clear-on-free is applied before the increment so a write landing in
    // the same cycle as the free counts as the first word of the new fill.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            cnt_d[b] = (rd_free && (rd_bank_q == b[0])) ? '0 : cnt_q[b];
            if (wr_accept && (bus.i_mem_select == b[0]) && (cnt_d[b] != CNT_MAX)) begin
                cnt_d[b] = cnt_d[b] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    assign bus.wr_count0 = cnt_q[0];
    assign bus.wr_count1 = cnt_q[1];
`else
    assign bus.wr_count0 = '0;
    assign bus.wr_count1 = '0;
`endif

    assign bus.rd_data  = rd_sel_q ? bank_rdata[1] : bank_rdata[0];
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_ready = rd_ready_q;
    assign bus.rd_bank  = rd_bank_q;
    assign bus.wr_ready = wr_ready_q;
    assign bus.err      = err_q;

endmodule
